// File: rtl/counter_pkg.sv
// Shared counter encodings for the counter, display and timer blocks.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package counter_pkg;

    // Boundary behaviour selector
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Count direction selector
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    // Classification of what a single step does to the count
    typedef enum logic [1:0] {
        STEP_INC   = 2'd0,  // ordinary increment inside the range
        STEP_DEC   = 2'd1,  // ordinary decrement inside the range
        STEP_CLAMP = 2'd2,  // out-of-range value pulled back to limit, no boundary event
        STEP_BOUND = 2'd3   // boundary reached: wrap or saturate, raises terminal
    } step_kind_e;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler: emits one step every prescale+1 enabled cycles; clear restarts the period.
// Latency: step is combinational from the prescale register state in the current cycle.
// Backpressure: none; enable low freezes the period count, no step is produced.
module tick_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  step
);

    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  period_done;

    // A period is complete once the count reaches the programmed value; using >=
    // lets a prescale reduced mid-period take effect on the very next enabled cycle.
    assign period_done = (pre_cnt >= prescale);

    // Clear (load) overrides stepping so the loaded value is held for a full period.
    assign step = enable && !clear && period_done;

    // Period counter: restart on clear or completed period, hold while disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (clear) begin
            pre_cnt <= '0;
        end else if (enable) begin
            if (period_done) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/prescaled_counter.sv
// Up/down counter with prescaler, modulo limit, synchronous load and wrap/saturate mode.
// Latency: count, tick and terminal all register at the edge where the step is decided.
// Backpressure: none; enable gates the prescaler, load takes priority over stepping.
module prescaled_counter
    import counter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  direction,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    output logic [WIDTH-1:0]      count,
    output logic                  tick,
    output logic                  terminal
);

    logic             step;
    step_kind_e       step_kind;
    logic [WIDTH-1:0] next_count;
    logic             next_terminal;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clear    (load),
        .prescale (prescale),
        .step     (step)
    );

    // Classify the step against the limit; a loaded value above limit is
    // pulled back to limit on a down step without counting as a boundary.
    always_comb begin
        step_kind = STEP_INC;
        if (direction == DIR_UP) begin
            if (count < limit) begin
                step_kind = STEP_INC;
            end else begin
                step_kind = STEP_BOUND;
            end
        end else begin
            if (count > limit) begin
                step_kind = STEP_CLAMP;
            end else if (count != '0) begin
                step_kind = STEP_DEC;
            end else begin
                step_kind = STEP_BOUND;
            end
        end
    end

    // Value the count takes if this cycle steps, and whether it is a boundary event
    always_comb begin
        next_count    = count;
        next_terminal = 1'b0;
        unique case (step_kind)
            STEP_INC: begin
                next_count = count + 1'b1;
            end
            STEP_DEC: begin
                next_count = count - 1'b1;
            end
            STEP_CLAMP: begin
                next_count = limit;
            end
            STEP_BOUND: begin
                next_terminal = 1'b1;
                if (direction == DIR_UP) begin
                    // Up past the top: wrap to 0 or stick at limit
                    next_count = (mode == MODE_SAT) ? limit : '0;
                end else begin
                    // Down past 0: wrap to limit or stick at 0
                    next_count = (mode == MODE_SAT) ? '0 : limit;
                end
            end
            default: begin
                next_count    = count;
                next_terminal = 1'b0;
            end
        endcase
    end

    // Count and pulse registers: load beats step, pulses are single-cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            tick     <= 1'b0;
            terminal <= 1'b0;
        end else if (load) begin
            count    <= load_value;
            tick     <= 1'b0;
            terminal <= 1'b0;
        end else if (step) begin
            count    <= next_count;
            tick     <= 1'b1;
            terminal <= next_terminal;
        end else begin
            tick     <= 1'b0;
            terminal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prescaled_counter.sv
// Self-checking bench for prescaled_counter: per-cycle model comparison plus
// hand-computed literal expectations for each directed scenario.
// Runs to completion on its own and prints a single summary line.
module tb_prescaled_counter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        direction;
    logic [3:0]  prescale;
    logic [15:0] limit;
    logic        mode;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] count;
    logic        tick;
    logic        terminal;

    int errors = 0;
    int checks = 0;

    prescaled_counter #(
        .WIDTH      (16),
        .PRESCALE_W (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .direction  (direction),
        .prescale   (prescale),
        .limit      (limit),
        .mode       (mode),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .tick       (tick),
        .terminal   (terminal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_cnt: count value; m_en: enabled cycles accumulated toward the next step.
    int m_cnt, m_en, m_tick, m_term;
    int n_cnt, n_en, n_tick, n_term;
    int lim;

    always_comb begin
        n_cnt  = m_cnt;
        n_en   = m_en;
        n_tick = 0;
        n_term = 0;
        lim    = {16'd0, limit};
        if (load) begin
            n_cnt = {16'd0, load_value};
            n_en  = 0;
        end else if (enable) begin
            if (m_en + 1 >= {28'd0, prescale} + 1) begin
                n_en   = 0;
                n_tick = 1;
                if (direction) begin
                    if (m_cnt < lim) n_cnt = m_cnt + 1;
                    else begin
                        n_term = 1;
                        n_cnt  = mode ? lim : 0;
                    end
                end else begin
                    if (m_cnt > lim) n_cnt = lim;
                    else if (m_cnt > 0) n_cnt = m_cnt - 1;
                    else begin
                        n_term = 1;
                        n_cnt  = mode ? 0 : lim;
                    end
                end
            end else begin
                n_en = m_en + 1;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt  <= 0;
            m_en   <= 0;
            m_tick <= 0;
            m_term <= 0;
        end else begin
            m_cnt  <= n_cnt;
            m_en   <= n_en;
            m_tick <= n_tick;
            m_term <= n_term;
        end
    end

    // Compare process: every cycle outside reset, DUT against model
    always @(negedge clk) begin
        if (!reset) begin
            chk("model_count", int'(count), m_cnt);
            chk("model_tick", int'(tick), m_tick);
            chk("model_terminal", int'(terminal), m_term);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        load       = 1'b1;
        load_value = v;
        cyc(1);
        load       = 1'b0;
    endtask

    task automatic expect3(input string name, input int c, input int t, input int term);
        chk({name, "_count"}, int'(count), c);
        chk({name, "_tick"}, int'(tick), t);
        chk({name, "_terminal"}, int'(terminal), term);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        direction  = 1'b1;
        prescale   = 4'd0;
        limit      = 16'hFFFF;
        mode       = 1'b0;
        load       = 1'b0;
        load_value = 16'h0000;
        cyc(2);
        expect3("reset", 0, 0, 0);
        reset = 1'b0;

        // Prescale=3: ticks on enabled cycles 4, 8, 12 only
        prescale = 4'd3;
        enable   = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            chk("prescale_tick", int'(tick), (i % 4 == 0) ? 1 : 0);
        end
        chk("prescale_count12", int'(count), 3);
        enable = 1'b0;
        cyc(5);
        expect3("enable_gap", 3, 0, 0);

        // Reset mid-count: reach 0x0123 with a tick, then reset between edges
        prescale = 4'd0;
        do_load(16'h0122);
        chk("load_0122", int'(count), 16'h0122);
        enable = 1'b1;
        cyc(1);
        enable = 1'b0;
        expect3("pre_reset", 16'h0123, 1, 0);
        #2 reset = 1'b1;
        #1;
        expect3("async_reset", 0, 0, 0);
        cyc(1);
        reset  = 1'b0;
        enable = 1'b1;
        cyc(1);
        enable = 1'b0;
        expect3("after_reset", 1, 1, 0);

        // Wrap, limit 9: up from 8 -> 9, 0, 1
        limit = 16'd9;
        mode  = 1'b0;
        do_load(16'd8);
        enable = 1'b1;
        cyc(1); expect3("wrap_up9", 9, 1, 0);
        cyc(1); expect3("wrap_up0", 0, 1, 1);
        cyc(1); expect3("wrap_up1", 1, 1, 0);
        // Down from 1 -> 0, 9
        direction = 1'b0;
        cyc(1); expect3("wrap_dn0", 0, 1, 0);
        cyc(1); expect3("wrap_dn9", 9, 1, 1);
        enable = 1'b0;
        cyc(1); expect3("wrap_idle", 9, 0, 0);

        // Saturate, limit 5: up from 4 -> 5, 5, 5
        limit     = 16'd5;
        mode      = 1'b1;
        direction = 1'b1;
        do_load(16'd4);
        enable = 1'b1;
        cyc(1); expect3("sat_up5a", 5, 1, 0);
        cyc(1); expect3("sat_up5b", 5, 1, 1);
        cyc(1); expect3("sat_up5c", 5, 1, 1);
        enable = 1'b0;
        // Down from 0 holds 0 with terminal
        direction = 1'b0;
        do_load(16'd0);
        enable = 1'b1;
        cyc(1); expect3("sat_dn0a", 0, 1, 1);
        cyc(1); expect3("sat_dn0b", 0, 1, 1);
        enable = 1'b0;

        // Out-of-range load, limit 5
        do_load(16'h00F0);
        chk("oor_load", int'(count), 16'h00F0);
        enable = 1'b1;
        cyc(1); expect3("oor_down", 5, 1, 0);
        enable    = 1'b0;
        mode      = 1'b0;
        direction = 1'b1;
        do_load(16'h00F0);
        enable = 1'b1;
        cyc(1); expect3("oor_up_wrap", 0, 1, 1);
        enable = 1'b0;

        // limit=0: pinned at 0, every step is terminal
        limit = 16'd0;
        do_load(16'd3);
        enable = 1'b1;
        cyc(1); expect3("lim0_a", 0, 1, 1);
        cyc(1); expect3("lim0_b", 0, 1, 1);
        enable = 1'b0;

        // Load colliding with a due step: load wins, period restarts
        limit    = 16'hFFFF;
        prescale = 4'd3;
        do_load(16'd0);
        enable = 1'b1;
        cyc(3);
        expect3("coll_pre", 0, 0, 0);
        load       = 1'b1;
        load_value = 16'h00AA;
        cyc(1);
        load = 1'b0;
        expect3("coll_load", 16'h00AA, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            cyc(1);
            expect3("coll_wait", 16'h00AA, 0, 0);
        end
        cyc(1);
        expect3("coll_step", 16'h00AB, 1, 0);
        enable = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
